// File: rtl/raybox_pkg.sv
// raybox_pkg: display timing, trace pipeline lead and reader FSM encoding shared by the raybox blocks
package raybox_pkg;
  localparam logic [9:0] H_VIEW     = 10'd640;
  localparam logic [9:0] H_TOTAL    = 10'd800;
  localparam logic [9:0] V_VIEW     = 10'd480;
  localparam logic [9:0] V_TOTAL    = 10'd525;
  localparam logic [9:0] V_HALF     = 10'd240;
  localparam logic [9:0] TRACE_LEAD = 10'd2;
  typedef enum logic [2:0] {
    IDLE,
    PREFETCH,
    STREAM,
    DRAIN,
    HBLANK
  } trace_state_e;
endpackage

// File: rtl/wall_span.sv
// wall_span: clamps a column's wall half-height and classifies a line as ceiling, wall or floor
module wall_span
  import raybox_pkg::*;
(
  input  logic [9:0] height,
  input  logic [9:0] vpos,
  output logic       wall_en,
  output logic       is_ceiling,
  output logic       is_floor
);
  logic [9:0] h;
  logic [9:0] top;
  logic [9:0] bottom;
  assign h          = height > V_HALF ? V_HALF : height;
  assign top        = V_HALF - h;
  assign bottom     = V_HALF + h;
  assign is_ceiling = vpos < top;
  assign is_floor   = vpos >= bottom;
  assign wall_en    = !is_ceiling && !is_floor;
endmodule

// File: rtl/trace_reader.sv
// trace_reader: streams per-column trace entries two pixels ahead of the beam and
// hands the trace buffer to the writer during vertical blanking
module trace_reader
  import raybox_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
  output logic        tb_cs,
  output logic        tb_oe,
  output logic        tb_we,
  output logic [9:0]  tb_column,
  input  logic [15:0] tb_distance,
  input  logic        tb_side,
  input  logic [5:0]  tb_tex,
  output logic        wall_en,
  output logic        is_ceiling,
  output logic        is_floor,
  output logic        wall_side,
  output logic [5:0]  wall_tex,
  output logic        bus_free
);
  trace_state_e state, state_n;
  logic [9:0] hnext;
  logic [9:0] vnext;
  logic       line_end;
  logic       pre_line;
  logic       vis;
  logic       span_wall;
  logic       span_ceil;
  logic       span_floor;
  assign line_end = hpos == H_TOTAL - 10'd1;
  assign hnext    = line_end ? '0 : hpos + 10'd1;
  assign vnext    = !line_end ? vpos : (vpos == V_TOTAL - 10'd1) ? '0 : vpos + 10'd1;
  assign pre_line = (vpos < V_VIEW - 10'd1) || (vpos == V_TOTAL - 10'd1);
  // every state re-checks the beam position so a sync generator jump falls back to IDLE
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:     state_n = (hpos == H_TOTAL - 10'd3 && pre_line) ? PREFETCH : IDLE;
      PREFETCH: state_n = (hpos == H_TOTAL - 10'd2 && pre_line) ? PREFETCH :
                          (line_end && vnext < V_VIEW) ? STREAM : IDLE;
      STREAM:   state_n = (vpos >= V_VIEW || hpos > H_VIEW - 10'd3) ? IDLE :
                          (hpos == H_VIEW - 10'd3) ? DRAIN : STREAM;
      DRAIN:    state_n = hpos == H_VIEW - 10'd2 ? DRAIN : hpos == H_VIEW - 10'd1 ? HBLANK : IDLE;
      HBLANK:   state_n = (hpos == H_TOTAL - 10'd3 && pre_line) ? PREFETCH :
                          (hpos >= H_VIEW && hpos < H_TOTAL - 10'd3) ? HBLANK : IDLE;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  assign tb_cs     = state == PREFETCH || state == STREAM;
  assign tb_oe     = tb_cs;
  assign tb_we     = 1'b0;
  assign tb_column = state == PREFETCH ? hpos - (H_TOTAL - TRACE_LEAD) :
                     state == STREAM   ? hpos + TRACE_LEAD : '0;
  // read data is live exactly when the FSM stays in the stream; it lands on the next pixel
  assign vis = (state_n == STREAM || state_n == DRAIN) && vnext < V_VIEW;
  wall_span u_span (
    .height     (tb_distance[15:6]),
    .vpos       (vnext),
    .wall_en    (span_wall),
    .is_ceiling (span_ceil),
    .is_floor   (span_floor)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wall_en    <= 1'b0;
      is_ceiling <= 1'b0;
      is_floor   <= 1'b0;
      wall_side  <= 1'b0;
      wall_tex   <= '0;
      bus_free   <= 1'b0;
    end else begin
      wall_en    <= vis && span_wall;
      is_ceiling <= vis && span_ceil;
      is_floor   <= vis && span_floor;
      wall_side  <= vis && tb_side;
      wall_tex   <= vis ? tb_tex : '0;
      bus_free   <= vnext >= V_VIEW && !(vnext == V_TOTAL - 10'd1 && hnext >= H_TOTAL - 10'd4);
    end
endmodule

// File: tb/tb_trace_reader.sv
// tb_trace_reader: sweeps selected lines against a per-pixel reference model of the trace reader
module tb_trace_reader;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  hpos = 10'd700;
  logic [9:0]  vpos = 10'd236;
  logic        tb_cs, tb_oe, tb_we;
  logic [9:0]  tb_column;
  logic [15:0] tb_distance = '0;
  logic        tb_side = 1'b0;
  logic [5:0]  tb_tex = '0;
  logic        wall_en, is_ceiling, is_floor, wall_side, bus_free;
  logic [5:0]  wall_tex;
  logic [15:0] dist_mem [640];
  logic        side_mem [640];
  logic [5:0]  tex_mem  [640];
  int errors = 0;
  int checks = 0;
  bit armed = 0;
  bit edge_ok = 0;
  trace_reader dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .hpos        (hpos),
    .vpos        (vpos),
    .tb_cs       (tb_cs),
    .tb_oe       (tb_oe),
    .tb_we       (tb_we),
    .tb_column   (tb_column),
    .tb_distance (tb_distance),
    .tb_side     (tb_side),
    .tb_tex      (tb_tex),
    .wall_en     (wall_en),
    .is_ceiling  (is_ceiling),
    .is_floor    (is_floor),
    .wall_side   (wall_side),
    .wall_tex    (wall_tex),
    .bus_free    (bus_free)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (tb_cs && tb_oe && tb_column < 10'd640) begin
      tb_distance <= dist_mem[tb_column];
      tb_side     <= side_mem[tb_column];
      tb_tex      <= tex_mem[tb_column];
    end
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at v=%0d h=%0d: got %0h expected %0h", tag, vpos, hpos, got, exp);
    end
  endtask
  task automatic run_cycle();
    int h = int'(hpos);
    int v = int'(vpos);
    int nl = (v == 524) ? 0 : v + 1;
    int hh = 0;
    bit ecs, vis, ec, ef, ew, ebf;
    if (!reset_n) armed = 0;
    else if (h == 798 && nl < 480) armed = 1;
    ecs = armed && ((h >= 798 && nl < 480) || (h < 638 && v < 480));
    vis = armed && h < 640 && v < 480;
    ec = 0;
    ef = 0;
    if (vis) begin
      hh = int'(dist_mem[h] >> 6);
      if (hh > 240) hh = 240;
      ec = v < 240 - hh;
      ef = v >= 240 + hh;
    end
    ew = vis && !ec && !ef;
    ebf = reset_n && edge_ok && v >= 480 && !(v == 524 && h >= 796);
    @(negedge clk);
    check("tb_cs", 16'(tb_cs), 16'(ecs));
    check("tb_oe", 16'(tb_oe), 16'(ecs));
    check("tb_we", 16'(tb_we), 16'd0);
    if (ecs) check("tb_column", 16'(tb_column), 16'(h >= 798 ? h - 798 : h + 2));
    check("wall_en", 16'(wall_en), 16'(ew));
    check("is_ceiling", 16'(is_ceiling), 16'(ec));
    check("is_floor", 16'(is_floor), 16'(ef));
    check("wall_side", 16'(wall_side), 16'(vis ? side_mem[h] : 1'b0));
    check("wall_tex", 16'(wall_tex), 16'(vis ? tex_mem[h] : 6'd0));
    check("bus_free", 16'(bus_free), 16'(ebf));
    @(posedge clk);
    edge_ok = reset_n;
    #1;
    hpos = (h == 799) ? 10'd0 : 10'(h + 1);
    if (h == 799) vpos = (v == 524) ? 10'd0 : 10'(v + 1);
  endtask
  task automatic run_until(input int tv, input int th);
    int n = 0;
    while (!(int'(vpos) == tv && int'(hpos) == th)) begin
      run_cycle();
      n++;
      if (n > 60000) begin
        errors++;
        $display("FAIL run_until timeout: at v=%0d h=%0d, wanted v=%0d h=%0d", vpos, hpos, tv, th);
        break;
      end
    end
  endtask
  initial begin
    for (int c = 0; c < 640; c++) begin
      case (c % 4)
        0:       dist_mem[c] = 16'(c << 6);
        2:       dist_mem[c] = (c % 8 == 2) ? 16'hFFFF : 16'h0000;
        default: dist_mem[c] = 16'($urandom_range(0, 65535));
      endcase
      side_mem[c] = 1'($urandom_range(0, 1));
      tex_mem[c]  = 6'($urandom_range(0, 63));
    end
    dist_mem[5]   = 16'h0A00;
    side_mem[639] = 1'b1;
    tex_mem[639]  = 6'h2A;
    repeat (10) run_cycle();
    reset_n = 1'b1;
    run_until(241, 700);
    vpos = 10'd198;
    run_until(201, 700);
    vpos = 10'd278;
    run_until(281, 100);
    #1 reset_n = 1'b0;
    repeat (6) run_cycle();
    reset_n = 1'b1;
    run_until(282, 700);
    vpos = 10'd477;
    run_until(1, 700);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/trace_reader.md
Name: trace_reader

Overview:
- Read-side client of the per-column trace buffer. The buffer holds one 16-bit distance, 1-bit side and 6-bit tex entry per column, with a 1-cycle registered read.
- During each visible scanline it streams columns 0..639 out of the buffer, timed so each column's data is registered exactly on its pixel.
- It converts the distance field to a wall span and emits per-pixel wall/ceiling/floor flags for the pixel colour stage.
- Outside the active area it releases the buffer and flags the trace writer that it may write.

Parameters:
- H_VIEW, 640, visible pixels per line (also the number of buffer entries).
- H_TOTAL, 800, clocks per line.
- V_VIEW, 480, visible lines.
- V_TOTAL, 525, lines per frame.
- V_HALF, 240, screen vertical centre and wall half-height clamp.

Ports:
- clk  in  1  pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- hpos  in  10  current pixel x from sync generator, 0..H_TOTAL-1.
- vpos  in  10  current line from sync generator, 0..V_TOTAL-1.
- tb_cs  out  1  trace buffer chip select.
- tb_oe  out  1  trace buffer output enable.
- tb_we  out  1  trace buffer write enable; constant 0.
- tb_column  out  10  trace buffer address.
- tb_distance  in  16  buffer read data: wall half-height, unsigned Q10.6.
- tb_side  in  1  buffer read data: side flag.
- tb_tex  in  6  buffer read data: texture id.
- wall_en  out  1  current pixel is wall.
- is_ceiling  out  1  current pixel is above the wall.
- is_floor  out  1  current pixel is below the wall.
- wall_side  out  1  side of the current column.
- wall_tex  out  6  tex of the current column.
- bus_free  out  1  writer may drive the trace buffer.

Behaviour:
- Reset (async, reset_n=0):
  - All outputs go to 0 immediately and the FSM enters IDLE.
  - A reset mid-line aborts the stream. The next valid stream starts at the next PREFETCH window.
- Pipeline, LEAD=2:
  - Column c is addressed (tb_cs=tb_oe=1, tb_column=c) on the cycle where the effective hpos equals c-2, modulo H_TOTAL.
  - The buffer returns data the cycle after that.
  - The reader registers its outputs on the following edge, so they are valid on the cycle where hpos=c.
- "Stream line": a line L with L<V_VIEW. Its prefetch happens on line L-1, or on line V_TOTAL-1 for L=0.
- FSM states:
  - IDLE: cs low. Go to PREFETCH when hpos=H_TOTAL-2 on the line preceding a stream line.
  - PREFETCH: 2 cycles, issuing columns 0 and 1. Then go to STREAM.
  - STREAM: while hpos=0..H_VIEW-3, issue column hpos+2. After hpos=H_VIEW-3, go to DRAIN.
  - DRAIN: 2 cycles with cs low while columns H_VIEW-2 and H_VIEW-1 emerge. Then go to HBLANK.
  - HBLANK: cs low. Go to PREFETCH at hpos=H_TOTAL-2 if the next line is a stream line, else go to IDLE.
- tb_cs and tb_oe are asserted only in PREFETCH and STREAM. tb_we is never asserted.
- Span arithmetic, for the registered column:
  - h = min(tb_distance[15:6], V_HALF), 10-bit, saturating.
  - top = V_HALF-h; bottom = V_HALF+h.
  - wall_en = (vpos>=top && vpos<bottom).
  - is_ceiling = vpos<top.
  - is_floor = vpos>=bottom.
  - Exactly one of the three flags is 1 in the visible area.
  - h=0 gives no wall pixels: is_ceiling for vpos<240, is_floor otherwise.
- Outside the visible area (hpos>=H_VIEW or vpos>=V_VIEW): wall_en, is_ceiling, is_floor, wall_side and wall_tex are all 0.
- bus_free is registered:
  - It goes to 1 at the first cycle of line V_VIEW.
  - It goes to 0 at hpos=H_TOTAL-4 of line V_TOTAL-1, giving a 2-cycle guard before PREFETCH.
  - It is 0 at all other times and during reset.
- Simultaneous events: if hpos/vpos jump to a value inconsistent with the FSM (sync generator reset), the FSM re-enters IDLE on the next edge and the outputs are blanked until the next PREFETCH.

Decomposition:
- Shared package raybox_pkg: timing constants (H_VIEW, H_TOTAL, V_VIEW, V_TOTAL, V_HALF), TRACE_LEAD=2, and the FSM state encoding.
- One natural sub-module, wall_span: combinational clamp/compare from (distance, vpos) to wall_en, is_ceiling and is_floor.

Test Plan:
- Reset: hold reset_n=0 mid-STREAM at hpos=100 → all outputs 0 in the same cycle. Release → no cs until hpos=798 of the next prefetch line.
- Line 0 timing: preload column c with distance=c<<6, then sweep line 524 → line 0.
  - tb_column=0 at hpos=798 and 1 at hpos=799.
  - tb_column=hpos+2 for hpos 0..637.
  - cs low for hpos 638..797.
  - wall outputs for column c appear at hpos=c.
- Span: column 5 distance=16'h0A00 (h=40), vpos=199/200/279/280 → is_ceiling / wall_en / wall_en / is_floor respectively.
- Clamp: distance=16'hFFFF → h=240, wall_en=1 on every visible line. distance=0 → no wall_en, ceiling/floor split at 240.
- bus_free:
  - rises at the first cycle of line 480 and falls at hpos=796 of line 524.
  - tb_cs stays 0 throughout lines 480..523.
  - tb_we is 0 for the whole frame.
- Side/tex passthrough: column 639 side=1, tex=6'h2A → wall_side=1, wall_tex=2A at hpos=639 only; both 0 at hpos=640.
